// File: rtl/keyin_sequencer_if.sv
// -----------------------------------------------------------------------------
// keyin_sequencer_if
//   Bundles the request side (start/value_in/op_in) and the key-stream side
//   (enc_out/pressed plus status) of the key-entry sequencer.
//
//   Optional feature macro: KEYSEQ_ABORT_EN adds the 'abort' request line.
//
//   Signals:
//     start     request to send a sequence (sampled only when idle)
//     value_in  16-bit value, [15:12] sent first
//     op_in     operation code latched with the sequence
//     abort     (KEYSEQ_ABORT_EN only) cancel the running sequence
//     enc_out   key code currently presented
//     pressed   key-down strobe
//     op_out    latched operation code
//     busy      sequence in progress
//     done      one-cycle completion pulse
//     err       one-cycle rejection / abort pulse
//     key_idx   1..4 digit, 5 Enter, 0 idle
//   Modports: master drives requests (bench / host), slave is the sequencer.
// -----------------------------------------------------------------------------
interface keyin_sequencer_if;
    logic        start;
    logic [15:0] value_in;
    logic [1:0]  op_in;
`ifdef KEYSEQ_ABORT_EN
    logic        abort;
`endif
    logic [3:0]  enc_out;
    logic        pressed;
    logic [1:0]  op_out;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  key_idx;

`ifdef KEYSEQ_ABORT_EN
    modport master (
        output start, value_in, op_in, abort,
        input  enc_out, pressed, op_out, busy, done, err, key_idx
    );
    modport slave (
        input  start, value_in, op_in, abort,
        output enc_out, pressed, op_out, busy, done, err, key_idx
    );
`else
    modport master (
        output start, value_in, op_in,
        input  enc_out, pressed, op_out, busy, done, err, key_idx
    );
    modport slave (
        input  start, value_in, op_in,
        output enc_out, pressed, op_out, busy, done, err, key_idx
    );
`endif
endinterface

// File: rtl/keyin_sequencer.sv
// -----------------------------------------------------------------------------
// keyin_sequencer
//   Replays a 16-bit value as a timed key-press stream: four hex digits
//   (MSB nibble first) followed by the Enter code. Each key is held pressed
//   for PRESS_CYC cycles and released for GAP_CYC cycles so that the
//   downstream 4-digit-plus-Enter collector registers it exactly once.
//
//   Optional feature macro: KEYSEQ_ABORT_EN (adds bus.abort; cancels a running
//   sequence, pulses err, no done).
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    keyin_sequencer_if.slave (start/value_in/op_in[/abort] in;
//            enc_out/pressed/op_out/busy/done/err/key_idx out, all registered)
//
//   Parameters:
//     PRESS_CYC   cycles pressed is high per key (1..255)
//     GAP_CYC     cycles pressed is low after each key (1..255)
//     ENTER_CODE  code sent as the final key
// -----------------------------------------------------------------------------
module keyin_sequencer #(
    parameter int unsigned PRESS_CYC  = 4,
    parameter int unsigned GAP_CYC    = 4,
    parameter logic [3:0]  ENTER_CODE = 4'hE
) (
    input  logic              clk,
    input  logic              rst_n,
    keyin_sequencer_if.slave  bus
);

    // ARM is the one busy cycle between the accepted start and the first
    // press edge; it lets the first key's code and pressed rise together.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PRESS,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [7:0] PRESS_LOAD = 8'(PRESS_CYC - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYC - 1);
    localparam logic [3:0] EMPTY_CODE = 4'hF;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [15:0] value_q;
    logic [3:0]  enc_q;
    logic        pressed_q;
    logic [1:0]  op_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [2:0]  key_q;

    logic [3:0]  next_code_d;
    logic        abort_req;
    logic        abort_hit;

    // 4'hF is the collector's empty code; sending it would stall the collector.
    function automatic logic has_empty(input logic [15:0] v);
        return (v[15:12] == EMPTY_CODE) || (v[11:8] == EMPTY_CODE) ||
               (v[7:4]   == EMPTY_CODE) || (v[3:0]  == EMPTY_CODE);
    endfunction

    function automatic logic [3:0] code_for(input logic [15:0] v, input logic [2:0] k);
        logic [3:0] c;
        case (k)
            3'd1:    c = v[15:12];
            3'd2:    c = v[11:8];
            3'd3:    c = v[7:4];
            3'd4:    c = v[3:0];
            3'd5:    c = ENTER_CODE;
            default: c = EMPTY_CODE;
        endcase
        return c;
    endfunction

    // Code of the key that follows the current one (used on GAP -> PRESS).
    always_comb begin
        next_code_d = code_for(value_q, key_q + 3'd1);
    end

`ifdef KEYSEQ_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif
    assign abort_hit = abort_req && busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            value_q   <= 16'd0;
            enc_q     <= EMPTY_CODE;
            pressed_q <= 1'b0;
            op_q      <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            key_q     <= 3'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort_hit) begin
                state_q   <= S_IDLE;
                cnt_q     <= 8'd0;
                enc_q     <= EMPTY_CODE;
                pressed_q <= 1'b0;
                busy_q    <= 1'b0;
                key_q     <= 3'd0;
                err_q     <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // abort in the same idle cycle silently swallows start
                        if (bus.start && !abort_req) begin
                            if (has_empty(bus.value_in)) begin
                                err_q <= 1'b1;
                            end else begin
                                value_q <= bus.value_in;
                                op_q    <= bus.op_in;
                                busy_q  <= 1'b1;
                                key_q   <= 3'd1;
                                cnt_q   <= 8'd0;
                                state_q <= S_ARM;
                            end
                        end
                    end
                    S_ARM: begin
                        pressed_q <= 1'b1;
                        enc_q     <= code_for(value_q, key_q);
                        cnt_q     <= PRESS_LOAD;
                        state_q   <= S_PRESS;
                    end
                    S_PRESS: begin
                        if (cnt_q == 8'd0) begin
                            pressed_q <= 1'b0;
                            cnt_q     <= GAP_LOAD;
                            state_q   <= S_GAP;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    S_GAP: begin
                        if (cnt_q == 8'd0) begin
                            if (key_q == 3'd5) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                key_q   <= 3'd0;
                                enc_q   <= EMPTY_CODE;
                                cnt_q   <= 8'd0;
                                state_q <= S_DONE;
                            end else begin
                                // code changes on the press entry edge only
                                key_q     <= key_q + 3'd1;
                                enc_q     <= next_code_d;
                                pressed_q <= 1'b1;
                                cnt_q     <= PRESS_LOAD;
                                state_q   <= S_PRESS;
                            end
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    S_DONE: begin
                        // start is ignored here; accepted from the next cycle
                        cnt_q   <= 8'd0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        cnt_q   <= 8'd0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.enc_out = enc_q;
    assign bus.pressed = pressed_q;
    assign bus.op_out  = op_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.key_idx = key_q;

endmodule
